// File: rtl/router_b_pipe_if.sv
// Operand-router bus: sequencer/Data Bank command side, temp-file write-back and AU operand side.
// master = command/AU-side driver, slave = router_b_pipe.
interface router_b_pipe_if #(
  parameter int unsigned W    = 24,
  parameter int unsigned NTMP = 4
);
  localparam int unsigned TW = $clog2(NTMP);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [1:0]    sel_R;
  logic [1:0]    sel_S;
  logic [TW-1:0] tidx_R;
  logic [TW-1:0] tidx_S;
  logic          inv_R;
  logic          inv_S;
  logic [1:0]    sel_I;
  logic          tmp_we;
  logic [TW-1:0] tmp_waddr;
  logic [W-1:0]  tmp_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  R;
  logic [W-1:0]  S;
  logic [W-1:0]  I;
  logic          msb_R;
  logic          msb_S;

  modport master (
    output in_valid, A, B, sel_R, sel_S, tidx_R, tidx_S, inv_R, inv_S, sel_I,
           tmp_we, tmp_waddr, tmp_wdata, out_ready,
    input  in_ready, out_valid, R, S, I, msb_R, msb_S
  );

  modport slave (
    input  in_valid, A, B, sel_R, sel_S, tidx_R, tidx_S, inv_R, inv_S, sel_I,
           tmp_we, tmp_waddr, tmp_wdata, out_ready,
    output in_ready, out_valid, R, S, I, msb_R, msb_S
  );
endinterface

// File: rtl/router_b_pipe.sv
// Pipelined AU operand router: R/S/I selection, NTMP-entry temp file, 2-entry skid output buffer.
// Optional macro ROUTER_B_BYPASS_EN: write-first forwarding of same-cycle temp writes into the captured operands.
module router_b_pipe #(
  parameter int unsigned W    = 24,
  parameter int unsigned NTMP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  router_b_pipe_if.slave bus
);
  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] s;
    logic [W-1:0] i;
  } bundle_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  logic [W-1:0] tmp [NTMP];
  logic [W-1:0] tr_c, ts_c, sr_c, ss_c;
  bundle_t      op_c;
  bundle_t      m, k;
  state_t       state;
  logic         out_valid, in_ready;
  logic         accept_c, drain_c;

  // Temp file, written back from the AU result independent of the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < int'(NTMP); e++) tmp[e] <= '0;
    end else if (bus.tmp_we) begin
      tmp[bus.tmp_waddr] <= bus.tmp_wdata;
    end
  end

  // Operand selection for the bundle captured on accept
  always_comb begin
    tr_c = tmp[bus.tidx_R];
    ts_c = tmp[bus.tidx_S];
`ifdef ROUTER_B_BYPASS_EN
    if (bus.tmp_we && (bus.tmp_waddr == bus.tidx_R)) tr_c = bus.tmp_wdata;
    if (bus.tmp_we && (bus.tmp_waddr == bus.tidx_S)) ts_c = bus.tmp_wdata;
`endif
    case (bus.sel_R)
      2'b00:   sr_c = bus.A;
      2'b01:   sr_c = tr_c;
      2'b10:   sr_c = '0;
      default: sr_c = '1;
    endcase
    case (bus.sel_S)
      2'b00:   ss_c = bus.B;
      2'b01:   ss_c = ts_c;
      2'b10:   ss_c = '0;
      default: ss_c = '1;
    endcase
    op_c.r = bus.inv_R ? ~sr_c : sr_c;
    op_c.s = bus.inv_S ? ~ss_c : ss_c;
    case (bus.sel_I)
      2'b01:   op_c.i = W'(1);
      2'b10:   op_c.i = '1;
      default: op_c.i = '0;
    endcase
  end

  assign accept_c = bus.in_valid && in_ready;
  assign drain_c  = out_valid && bus.out_ready;

  // Skid buffer: M drives the outputs, K holds the second entry; in_ready comes from state only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      m         <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept_c) begin
            m         <= op_c;
            state     <= ST_ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_c && drain_c) begin
            m <= op_c;
          end else if (accept_c) begin
            k        <= op_c;
            state    <= ST_TWO;
            in_ready <= 1'b0;
          end else if (drain_c) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (drain_c) begin
            m        <= k;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.R         = m.r;
  assign bus.S         = m.s;
  assign bus.I         = m.i;
  assign bus.msb_R     = m.r[W-1];
  assign bus.msb_S     = m.s[W-1];
endmodule

// File: tb/tb_router_b_pipe.sv
// Self-checking bench for router_b_pipe: directed vector table plus handshake corner sequences.
module tb_router_b_pipe;
  localparam int unsigned W    = 24;
  localparam int unsigned NTMP = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  router_b_pipe_if #(.W(W), .NTMP(NTMP)) bus ();

  router_b_pipe #(.W(W), .NTMP(NTMP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel_R;
    logic        inv_R;
    logic [1:0]  sel_S;
    logic        inv_S;
    logic [1:0]  sel_I;
    logic [23:0] exp_R;
    logic [23:0] exp_S;
    logic [23:0] exp_I;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_cmd(input logic v, input logic [1:0] sr, input logic [1:0] tr, input logic ir,
                         input logic [1:0] ss, input logic [1:0] ts, input logic is_,
                         input logic [1:0] si);
    bus.in_valid = v;
    bus.sel_R    = sr;
    bus.tidx_R   = tr;
    bus.inv_R    = ir;
    bus.sel_S    = ss;
    bus.tidx_S   = ts;
    bus.inv_S    = is_;
    bus.sel_I    = si;
  endtask

  task automatic wr_tmp(input logic [1:0] addr, input logic [23:0] data);
    bus.tmp_we    = 1'b1;
    bus.tmp_waddr = addr;
    bus.tmp_wdata = data;
    @(negedge clk);
    bus.tmp_we    = 1'b0;
  endtask

  logic [23:0] q [$];
  logic [23:0] ra;
  logic        iv, orr, ir_save, acc, drn;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.A = '0; bus.B = '0;
    bus.tmp_we = 1'b0; bus.tmp_waddr = '0; bus.tmp_wdata = '0;
    bus.out_ready = 1'b1;
    set_cmd(1'b0, 2'b00, 2'd0, 1'b0, 2'b00, 2'd0, 1'b0, 2'b00);

    vecs[0] = '{2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 24'h123456, 24'hABCDEF, 24'h000000};
    vecs[1] = '{2'd1, 1'b0, 2'd1, 1'b0, 2'd1, 24'h0FF00D, 24'hC0FFEE, 24'h000001};
    vecs[2] = '{2'd1, 1'b1, 2'd1, 1'b1, 2'd2, 24'hF00FF2, 24'h3F0011, 24'hFFFFFF};
    vecs[3] = '{2'd2, 1'b0, 2'd3, 1'b0, 2'd3, 24'h000000, 24'hFFFFFF, 24'h000000};
    vecs[4] = '{2'd3, 1'b1, 2'd2, 1'b1, 2'd0, 24'h000000, 24'hFFFFFF, 24'h000000};
    vecs[5] = '{2'd0, 1'b1, 2'd0, 1'b1, 2'd1, 24'hEDCBA9, 24'h543210, 24'h000001};
    vecs[6] = '{2'd2, 1'b1, 2'd3, 1'b1, 2'd2, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    vecs[7] = '{2'd3, 1'b0, 2'd1, 1'b1, 2'd3, 24'hFFFFFF, 24'h3F0011, 24'h000000};

    // Reset values
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_R", 32'(bus.R), 32'h0);
    chk("rst_S", 32'(bus.S), 32'h0);
    chk("rst_I", 32'(bus.I), 32'h0);
    chk("rst_msb", 32'({bus.msb_R, bus.msb_S}), 32'd0);
    set_cmd(1'b1, 2'b01, 2'd2, 1'b0, 2'b10, 2'd0, 1'b0, 2'b00);
    @(negedge clk);
    chk("rst_tmp2_valid", 32'(bus.out_valid), 32'd1);
    chk("rst_tmp2_R", 32'(bus.R), 32'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Directed sweep vectors at full throughput
    bus.A = 24'h123456;
    bus.B = 24'hABCDEF;
    wr_tmp(2'd1, 24'h0FF00D);
    wr_tmp(2'd3, 24'hC0FFEE);
    for (int v = 0; v < 8; v++) begin
      set_cmd(1'b1, vecs[v].sel_R, 2'd1, vecs[v].inv_R, vecs[v].sel_S, 2'd3, vecs[v].inv_S, vecs[v].sel_I);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", v), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_R", v), 32'(bus.R), 32'(vecs[v].exp_R));
      chk($sformatf("vec%0d_S", v), 32'(bus.S), 32'(vecs[v].exp_S));
      chk($sformatf("vec%0d_I", v), 32'(bus.I), 32'(vecs[v].exp_I));
      chk($sformatf("vec%0d_msbR", v), 32'(bus.msb_R), 32'(vecs[v].exp_R[23]));
      chk($sformatf("vec%0d_msbS", v), 32'(bus.msb_S), 32'(vecs[v].exp_S[23]));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sweep_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: three back-to-back commands with out_ready low
    bus.out_ready = 1'b0;
    set_cmd(1'b1, 2'b00, 2'd0, 1'b0, 2'b00, 2'd0, 1'b0, 2'b00);
    bus.A = 24'h000001;
    @(negedge clk);
    chk("bp_c1_R", 32'(bus.R), 32'h000001);
    chk("bp_ready1", 32'(bus.in_ready), 32'd1);
    bus.A = 24'h000002;
    @(negedge clk);
    chk("bp_c1_hold", 32'(bus.R), 32'h000001);
    chk("bp_ready2", 32'(bus.in_ready), 32'd0);
    bus.A = 24'h000003;
    @(negedge clk);
    chk("bp_c1_hold2", 32'(bus.R), 32'h000001);
    chk("bp_stall", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_c2_R", 32'(bus.R), 32'h000002);
    chk("bp_c2_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("bp_c3_R", 32'(bus.R), 32'h000003);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Same-cycle write and read of TMP[0]
    wr_tmp(2'd0, 24'h111111);
    bus.tmp_we = 1'b1; bus.tmp_waddr = 2'd0; bus.tmp_wdata = 24'h222222;
    set_cmd(1'b1, 2'b01, 2'd0, 1'b0, 2'b10, 2'd0, 1'b0, 2'b00);
    @(negedge clk);
    bus.tmp_we = 1'b0;
`ifdef ROUTER_B_BYPASS_EN
    chk("fwd_same_cycle", 32'(bus.R), 32'h222222);
`else
    chk("fwd_same_cycle", 32'(bus.R), 32'h111111);
`endif
    @(negedge clk);
    chk("fwd_next", 32'(bus.R), 32'h222222);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset while in state TWO
    wr_tmp(2'd2, 24'h5A5A5A);
    bus.out_ready = 1'b0;
    bus.A = 24'h0000AA;
    set_cmd(1'b1, 2'b00, 2'd0, 1'b0, 2'b00, 2'd0, 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_two_ready", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    for (int e = 0; e < int'(NTMP); e++) begin
      set_cmd(1'b1, 2'b01, 2'(e), 1'b0, 2'b01, 2'(e), 1'b1, 2'b00);
      @(negedge clk);
      chk($sformatf("post_rst_tmp%0d_R", e), 32'(bus.R), 32'h000000);
      chk($sformatf("post_rst_tmp%0d_S", e), 32'(bus.S), 32'hFFFFFF);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Random valid/ready against a FIFO model
    q.delete();
    bus.B = 24'h00BEEF;
    set_cmd(1'b0, 2'b00, 2'd0, 1'b0, 2'b00, 2'd0, 1'b0, 2'b00);
    for (int c = 0; c < 2000; c++) begin
      chk("rnd_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("rnd_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd_R", 32'(bus.R), 32'(q[0]));
        chk("rnd_S", 32'(bus.S), 32'h00BEEF);
      end
      iv  = 1'($urandom_range(0, 1));
      orr = 1'($urandom_range(0, 3) != 0);
      ra  = 24'($urandom);
      bus.out_ready = ~orr;
      #1 ir_save = bus.in_ready;
      bus.out_ready = orr;
      #1 chk("rnd_ready_comb", 32'(bus.in_ready), 32'(ir_save));
      bus.in_valid = iv;
      bus.A = ra;
      acc = iv && (q.size() < 2);
      drn = orr && (q.size() > 0);
      @(negedge clk);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(ra);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
